// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone SRAM controller: FSM encoding,
// wait-counter width and a constant-friendly log2 helper.
package wb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_e;

    localparam int CNT_W = 4;

    // Ceiling log2; clog2(1) = 0 so an 8-bit bus has no byte-offset bits.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/wb_sram_bank.sv
// Synchronous single-port RAM with per-byte write enables and a registered
// read port whose output register is the only state that is reset.
module wb_sram_bank
    import wb_pkg::*;
#(
    parameter int DW    = 32,
    parameter int DEPTH = 1024
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      we_i,
    input  logic                      re_i,
    input  logic [DW/8-1:0]           be_i,
    input  logic [clog2(DEPTH)-1:0]   addr_i,
    input  logic [DW-1:0]             wdata_i,
    output logic [DW-1:0]             rdata_o
);

    localparam int NB = DW / 8;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] rdata_q;

    // NOTE: the array has no reset so it maps onto a RAM macro; a reset
    // would force it into flops.
    always_ff @(posedge clk) begin
        for (int b = 0; b < NB; b++) begin
            if (we_i && be_i[b]) begin
                mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_sram_ctrl.sv
// Wishbone classic slave around wb_sram_bank with programmable wait states,
// cyc-abort and optional range checking (WB_SRAM_CTRL_RANGE_CHECK_EN).
module wb_sram_ctrl
    import wb_pkg::*;
#(
    parameter int             DW          = 32,
    parameter int             DEPTH       = 1024,
    parameter int             AW          = 32,
    parameter int             WAIT_STATES = 0,
    parameter logic [AW-1:0]  BASE_ADDR   = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wb_cyc_i,
    input  logic              wb_stb_i,
    input  logic              wb_we_i,
    input  logic [AW-1:0]     wb_adr_i,
    input  logic [DW-1:0]     wb_dat_i,
    input  logic [DW/8-1:0]   wb_sel_i,
    output logic [DW-1:0]     wb_dat_o,
    output logic              wb_ack_o,
    output logic              wb_err_o
);

    localparam int NB    = DW / 8;
    localparam int OFF_W = clog2(NB);
    localparam int IW    = clog2(DEPTH);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             we_q, we_d;
    logic             err_q, err_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic [DW-1:0]    dat_q, dat_d;
    logic [NB-1:0]    sel_q, sel_d;

    logic             req;
    logic             oor;
    logic [AW-1:0]    off;
    logic [IW-1:0]    bus_idx;

    logic             mem_we, mem_re;
    logic [IW-1:0]    mem_idx;
    logic [DW-1:0]    mem_dat;
    logic [NB-1:0]    mem_sel;

    assign req     = wb_cyc_i & wb_stb_i;
    assign off     = wb_adr_i - BASE_ADDR;
    assign bus_idx = IW'(off >> OFF_W);

`ifdef WB_SRAM_CTRL_RANGE_CHECK_EN
    localparam logic [AW:0] LIMIT = {1'b0, BASE_ADDR} + (AW+1)'(DEPTH * NB);
    assign oor = ({1'b0, wb_adr_i} < {1'b0, BASE_ADDR}) || ({1'b0, wb_adr_i} >= LIMIT);
`else
    assign oor = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            dat_q   <= '0;
            sel_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            err_q   <= err_d;
            idx_q   <= idx_d;
            dat_q   <= dat_d;
            sel_q   <= sel_d;
        end
    end

    // With zero wait states the RAM is accessed on the accepting edge, so the
    // bank is fed straight from the bus instead of from the latched request.
    always_comb begin
        // NOTE: every output gets a default first so no path infers a latch.
        state_d = state_q;
        cnt_d   = cnt_q;
        we_d    = we_q;
        err_d   = err_q;
        idx_d   = idx_q;
        dat_d   = dat_q;
        sel_d   = sel_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        mem_idx = idx_q;
        mem_dat = dat_q;
        mem_sel = sel_q;

        unique case (state_q)
            ST_IDLE: begin
                if (req) begin
                    we_d  = wb_we_i;
                    err_d = oor;
                    idx_d = bus_idx;
                    dat_d = wb_dat_i;
                    sel_d = wb_sel_i;
                    if (WAIT_STATES > 0) begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES - 1);
                    end else begin
                        state_d = ST_ACK;
                        mem_we  = wb_we_i & ~oor;
                        mem_re  = ~wb_we_i & ~oor;
                        mem_idx = bus_idx;
                        mem_dat = wb_dat_i;
                        mem_sel = wb_sel_i;
                    end
                end
            end
            ST_WAIT: begin
                if (!wb_cyc_i) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = ST_ACK;
                    mem_we  = we_q & ~err_q;
                    mem_re  = ~we_q & ~err_q;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            ST_ACK: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

`ifdef WB_SRAM_CTRL_RANGE_CHECK_EN
    assign wb_ack_o = (state_q == ST_ACK) & ~err_q;
    assign wb_err_o = (state_q == ST_ACK) &  err_q;
`else
    assign wb_ack_o = (state_q == ST_ACK);
    assign wb_err_o = 1'b0;
`endif

    wb_sram_bank #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_bank (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .re_i    (mem_re),
        .be_i    (mem_sel),
        .addr_i  (mem_idx),
        .wdata_i (mem_dat),
        .rdata_o (wb_dat_o)
    );

endmodule

// File: tb/tb_wb_sram_ctrl.sv
// Directed bench for wb_sram_ctrl: one instance with zero and one with three
// wait states; range-check expectations follow WB_SRAM_CTRL_RANGE_CHECK_EN.
module tb_wb_sram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        cyc  [2];
    logic        stb  [2];
    logic        we   [2];
    logic [31:0] adr  [2];
    logic [31:0] wdat [2];
    logic [3:0]  sel  [2];
    logic [31:0] rdat [2];
    logic        ack  [2];
    logic        err  [2];

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wb_sram_ctrl #(.DW(32), .DEPTH(1024), .AW(32), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(cyc[0]), .wb_stb_i(stb[0]), .wb_we_i(we[0]),
        .wb_adr_i(adr[0]), .wb_dat_i(wdat[0]), .wb_sel_i(sel[0]),
        .wb_dat_o(rdat[0]), .wb_ack_o(ack[0]), .wb_err_o(err[0])
    );

    wb_sram_ctrl #(.DW(32), .DEPTH(1024), .AW(32), .WAIT_STATES(3), .BASE_ADDR(32'h0)) u_ws3 (
        .clk(clk), .rst_n(rst_n),
        .wb_cyc_i(cyc[1]), .wb_stb_i(stb[1]), .wb_we_i(we[1]),
        .wb_adr_i(adr[1]), .wb_dat_i(wdat[1]), .wb_sel_i(sel[1]),
        .wb_dat_o(rdat[1]), .wb_ack_o(ack[1]), .wb_err_o(err[1])
    );

    typedef struct {
        int          dut;
        bit          w;
        logic [31:0] a;
        logic [31:0] wd;
        logic [3:0]  s;
        bit          chk_rd;
        logic [31:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One complete classic cycle; lat counts edges from request to ack/err, -1 on timeout.
    task automatic xfer(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output logic [31:0] rd, output int lat, output bit e);
        @(posedge clk); #1;
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; wdat[d] = wd; sel[d] = s;
        lat = -1; e = 1'b0; rd = '0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (ack[d] || err[d]) begin
                lat = k; e = err[d]; rd = rdat[d];
                break;
            end
        end
        @(posedge clk); #1;
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        int          lat;
        bit          e;
        int          acks;
        bit          exp_err;

        for (int d = 0; d < 2; d++) begin
            cyc[d] = 0; stb[d] = 0; we[d] = 0; adr[d] = 0; wdat[d] = 0; sel[d] = 0;
        end

        vecs.push_back('{0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h0,        1});
        vecs.push_back('{0, 1'b0, 32'h10, 32'h0,        4'hF, 1'b1, 32'hDEADBEEF, 1});
        vecs.push_back('{0, 1'b1, 32'h20, 32'h11223344, 4'hF, 1'b0, 32'h0,        1});
        vecs.push_back('{0, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, 1'b0, 32'h0,        1});
        vecs.push_back('{0, 1'b0, 32'h20, 32'h0,        4'hF, 1'b1, 32'h11BB33DD, 1});
        vecs.push_back('{0, 1'b1, 32'h23, 32'h000000EE, 4'h1, 1'b0, 32'h0,        1});
        vecs.push_back('{0, 1'b0, 32'h21, 32'h0,        4'hF, 1'b1, 32'h11BB33EE, 1});
        vecs.push_back('{0, 1'b1, 32'h24, 32'h01020304, 4'hF, 1'b0, 32'h0,        1});
        vecs.push_back('{0, 1'b1, 32'h24, 32'hCAFEF00D, 4'h0, 1'b0, 32'h0,        1});
        vecs.push_back('{0, 1'b0, 32'h24, 32'h0,        4'hF, 1'b1, 32'h01020304, 1});
        vecs.push_back('{1, 1'b1, 32'h30, 32'h00000077, 4'hF, 1'b0, 32'h0,        4});
        vecs.push_back('{1, 1'b0, 32'h30, 32'h0,        4'hF, 1'b1, 32'h00000077, 4});

        #12;
        check("reset ack0", 32'(ack[0]), 32'h0);
        check("reset err0", 32'(err[0]), 32'h0);
        check("reset dat0", rdat[0], 32'h0);
        check("reset ack1", 32'(ack[1]), 32'h0);
        check("reset dat1", rdat[1], 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            xfer(vecs[i].dut, vecs[i].w, vecs[i].a, vecs[i].wd, vecs[i].s, rd, lat, e);
            check($sformatf("vec%0d latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("vec%0d err", i), 32'(e), 32'h0);
            if (vecs[i].chk_rd) check($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rd);
        end

        // Wait states: stb held through the ack and one further cycle.
        @(posedge clk); #1;
        cyc[1] = 1; stb[1] = 1; we[1] = 0; adr[1] = 32'h30; sel[1] = 4'hF;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk);
            @(negedge clk);
            check($sformatf("ws3 ack at edge %0d", k), 32'(ack[1]), (k == 4) ? 32'h1 : 32'h0);
            if (k == 4) check("ws3 held rdata", rdat[1], 32'h00000077);
        end
        @(posedge clk);
        @(negedge clk);
        check("ws3 single ack pulse", 32'(ack[1]), 32'h0);
        cyc[1] = 0; stb[1] = 0;
        acks = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (ack[1]) acks++;
        end
        check("ws3 no second ack", 32'(acks), 32'h0);

        // Abort: cyc drops while the write is waiting.
        @(posedge clk); #1;
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h30; wdat[1] = 32'h55; sel[1] = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        cyc[1] = 0; stb[1] = 0; we[1] = 0;
        acks = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (ack[1] || err[1]) acks++;
        end
        check("abort no ack", 32'(acks), 32'h0);
        xfer(1, 1'b0, 32'h30, 32'h0, 4'hF, rd, lat, e);
        check("abort read latency", 32'(lat), 32'd4);
        check("abort old value", rd, 32'h00000077);

        // Reset mid-WAIT drops the pending write and clears outputs at once.
        @(posedge clk); #1;
        cyc[1] = 1; stb[1] = 1; we[1] = 1; adr[1] = 32'h30; wdat[1] = 32'h99; sel[1] = 4'hF;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        check("mid-wait reset ack", 32'(ack[1]), 32'h0);
        check("mid-wait reset err", 32'(err[1]), 32'h0);
        check("mid-wait reset dat", rdat[1], 32'h0);
        cyc[1] = 0; stb[1] = 0; we[1] = 0;
        @(negedge clk);
        rst_n = 1'b1;
        xfer(1, 1'b0, 32'h30, 32'h0, 4'hF, rd, lat, e);
        check("post-reset latency", 32'(lat), 32'd4);
        check("post-reset rdata", rd, 32'h00000077);

        // Out-of-range write at one past the window (4 KiB).
        xfer(0, 1'b1, 32'h0, 32'hA5A5A5A5, 4'hF, rd, lat, e);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, lat, e);
        check("word0 preload", rd, 32'hA5A5A5A5);
`ifdef WB_SRAM_CTRL_RANGE_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        xfer(0, 1'b1, 32'h1000, 32'h12345678, 4'hF, rd, lat, e);
        check("range latency", 32'(lat), 32'd1);
        check("range err flag", 32'(e), 32'(exp_err));
        if (exp_err) check("range dat_o unchanged", rd, 32'hA5A5A5A5);
        xfer(0, 1'b0, 32'h0, 32'h0, 4'hF, rd, lat, e);
        check("range word0", rd, exp_err ? 32'hA5A5A5A5 : 32'h12345678);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
